mem_port_arbiter: RTL and testbench

- Shares the core's single external memory port between three cache-side requesters: uncache (port 0), dcache (port 1) and icache (port 2).
- Serialises one burst transaction at a time: read refill, dcache writeback or uncached access.
- Sits between the cache/uncache controllers and the bus bridge.
- Fixed priority 0 > 1 > 2, with a starvation guard that promotes icache.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises burst transactions from uncache/dcache/icache onto one memory port
// Fixed priority 0 > 1 > 2 with an icache starvation guard; one burst in flight at a time.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int LEN_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req,
  input  logic [2:0]         we,
  input  logic [95:0]        addr,
  input  logic [3*LEN_W-1:0] len,
  input  logic [95:0]        wdata,
  input  logic [11:0]        wstrb,
  output logic [2:0]         gnt,
  output logic [2:0]         rvalid,
  output logic [2:0]         rlast,
  output logic [31:0]        rdata,
  output logic [2:0]         wready,
  output logic [2:0]         done,
  output logic               bus_req,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [LEN_W-1:0]   bus_len,
  input  logic               bus_addr_ok,
  input  logic               bus_rvalid,
  input  logic               bus_rlast,
  input  logic [31:0]        bus_rdata,
  output logic               bus_wvalid,
  output logic               bus_wlast,
  output logic [31:0]        bus_wdata,
  output logic [3:0]         bus_wstrb,
  input  logic               bus_wready,
  input  logic               bus_bvalid,
  output logic               busy,
  output logic               proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d, win;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             proto_q, proto_d;
  logic [2:0]       own_oh;

  // A saturated starve counter lets icache jump the fixed priority once.
  always_comb begin
    if (starve_q == SW'(STARVE_LIMIT) && req[2]) win = 2'd2;
    else if (req[0])                             win = 2'd0;
    else if (req[1])                             win = 2'd1;
    else                                         win = 2'd2;
  end

  assign own_oh    = 3'b001 << owner_q;
  assign rdata     = bus_rdata;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_len   = len_q;
  assign bus_wdata = wdata[32*owner_q +: 32];
  assign bus_wstrb = wstrb[4*owner_q +: 4];
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    starve_d   = starve_q;
    proto_d    = proto_q;
    gnt        = '0;
    rvalid     = '0;
    rlast      = '0;
    wready     = '0;
    done       = '0;
    bus_req    = 1'b0;
    bus_wvalid = 1'b0;
    bus_wlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt     = 3'b001 << win;
          owner_d = win;
          we_d    = we[win];
          addr_d  = addr[32*win +: 32];
          len_d   = len[LEN_W*win +: LEN_W];
          if (win == 2'd2)                                  starve_d = '0;
          else if (req[2] && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          beat_d  = '0;
          state_d = we_q ? WDATA : RDATA;
        end
      end
      RDATA: begin
        if (bus_rvalid) begin
          rvalid = own_oh;
          beat_d = beat_q + 1'b1;
          if (bus_rlast) begin
            rlast   = own_oh;
            state_d = IDLE;
            if (beat_q != len_q) proto_d = 1'b1;
          end
        end
      end
      WDATA: begin
        bus_wvalid = 1'b1;
        bus_wlast  = (beat_q == len_q);
        if (bus_wready) begin
          wready = own_oh;
          beat_d = beat_q + 1'b1;
          if (bus_wlast) state_d = WRESP;
        end
      end
      WRESP: begin
        if (bus_bvalid) begin
          done    = own_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      proto_q  <= proto_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LEN_W        = 4;
  localparam int STARVE_LIMIT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         req, we;
  logic [95:0]        addr, wdata;
  logic [3*LEN_W-1:0] len;
  logic [11:0]        wstrb;
  logic [2:0]         gnt, rvalid, rlast, wready, done;
  logic [31:0]        rdata, bus_addr, bus_wdata, bus_rdata;
  logic               bus_req, bus_we, bus_addr_ok, bus_rvalid, bus_rlast;
  logic [LEN_W-1:0]   bus_len;
  logic               bus_wvalid, bus_wlast, bus_wready, bus_bvalid, busy, proto_err;
  logic [3:0]         bus_wstrb;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len), .wdata(wdata),
    .wstrb(wstrb), .gnt(gnt), .rvalid(rvalid), .rlast(rlast), .rdata(rdata),
    .wready(wready), .done(done), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_len(bus_len), .bus_addr_ok(bus_addr_ok),
    .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
    .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wready(bus_wready), .bus_bvalid(bus_bvalid),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_starve;
  bit          m_proto;
  logic [2:0]  pend;
  logic        p_we   [3];
  logic [31:0] p_addr [3];
  logic [3:0]  p_len  [3];
  logic [31:0] p_wd   [3];
  logic [3:0]  p_ws   [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_winner(input logic [2:0] r);
    if (r[2] && m_starve >= STARVE_LIMIT) return 2;
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < 3; i++) begin
      we[i]                  = p_we[i];
      addr[32*i +: 32]       = p_addr[i];
      len[LEN_W*i +: LEN_W]  = p_len[i];
      wdata[32*i +: 32]      = p_wd[i];
      wstrb[4*i +: 4]        = p_ws[i];
    end
    req = pend;
  endtask

  task automatic set_port(input int i, input logic w, input logic [31:0] a, input logic [3:0] l);
    p_we[i] = w; p_addr[i] = a; p_len[i] = l; pend[i] = 1'b1;
  endtask

  task automatic rand_port(input int i);
    set_port(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
  endtask

  task automatic bus_idle();
    bus_addr_ok = 0; bus_rvalid = 0; bus_rlast = 0; bus_rdata = 0; bus_wready = 0; bus_bvalid = 0;
  endtask

  task automatic do_txn(input int err_at, input int addr_dly, input int use_pat,
                        input logic [7:0] pat, output int w);
    int d, last, idx, g, gaps;
    logic [31:0] rd;
    logic [31:0] bd [16];
    bit rdy;
    @(negedge clk);
    drive_ports();
    #1;
    w = model_winner(pend);
    check("busy_idle", busy, 0);
    check("gnt", gnt, 32'(1) << w);
    if (w == 2) m_starve = 0;
    else if (pend[2]) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    pend[w] = 1'b0;
    d = (addr_dly >= 0) ? addr_dly : $urandom_range(0, 2);
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      req = pend | 3'($urandom);
      bus_addr_ok = (k == d);
      #1;
      check("bus_req", bus_req, 1);
      check("bus_addr", bus_addr, p_addr[w]);
      check("bus_len", bus_len, p_len[w]);
      check("bus_we", bus_we, p_we[w]);
      check("gnt_busy", gnt, 0);
    end
    if (!p_we[w]) begin
      last = (err_at >= 0) ? err_at : p_len[w];
      for (int b = 0; b <= last; b++) begin
        gaps = ($urandom_range(0, 3) == 0) ? 1 : 0;
        for (int k = 0; k < gaps; k++) begin
          @(negedge clk); bus_idle(); #1;
          check("rvalid_gap", rvalid, 0);
        end
        @(negedge clk);
        bus_idle(); rd = $urandom;
        bus_rvalid = 1; bus_rdata = rd; bus_rlast = (b == last);
        #1;
        check("rvalid", rvalid, 32'(1) << w);
        check("rdata", rdata, rd);
        check("rlast", rlast, (b == last) ? (32'(1) << w) : 0);
      end
      if (last != p_len[w]) m_proto = 1;
    end else begin
      for (int b = 0; b <= p_len[w]; b++) bd[b] = $urandom;
      idx = 0; g = 0;
      while (idx <= p_len[w] && g < 200) begin
        @(negedge clk);
        bus_idle();
        p_wd[w] = bd[idx]; p_ws[w] = 4'($urandom);
        drive_ports();
        rdy = use_pat ? pat[g % 8] : 1'($urandom_range(0, 1));
        bus_wready = rdy;
        #1;
        check("wvalid", bus_wvalid, 1);
        check("wdata", bus_wdata, bd[idx]);
        check("wstrb", bus_wstrb, p_ws[w]);
        check("wlast", bus_wlast, idx == p_len[w]);
        check("wready", wready, rdy ? (32'(1) << w) : 0);
        if (rdy) idx++;
        g++;
      end
      d = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        bus_idle(); bus_rvalid = 1; bus_rlast = 1;
        #1;
        check("done_wait", done, 0);
        check("stray_rvalid", rvalid, 0);
        check("busy_wresp", busy, 1);
      end
      @(negedge clk);
      bus_idle(); bus_bvalid = 1;
      #1;
      check("done", done, 32'(1) << w);
    end
    @(negedge clk);
    bus_idle(); req = 3'b000;
    #1;
    check("busy_end", busy, 0);
    check("gnt_quiet", gnt, 0);
    check("done_end", done, 0);
    check("proto_err", proto_err, m_proto);
  endtask

  int w, win_at;

  initial begin
    rst = 1; pend = 0; req = 0; m_starve = 0; m_proto = 0;
    for (int i = 0; i < 3; i++) begin
      p_we[i] = 0; p_addr[i] = 0; p_len[i] = 0; p_wd[i] = 0; p_ws[i] = 0;
    end
    drive_ports(); bus_idle();
    @(negedge clk); #1;
    check("rst_out", {gnt, rvalid, rlast, wready, done}, 0);
    check("rst_bus", {bus_req, bus_wvalid, bus_wlast, busy, proto_err}, 0);
    @(negedge clk); rst = 0;

    set_port(2, 0, 32'h1FC0_0000, 4'd7);
    do_txn(-1, 1, 0, 0, w);

    for (int i = 0; i < 3; i++) set_port(i, 0, 32'h100 * (i + 1), 4'd0);
    for (int i = 0; i < 3; i++) begin
      do_txn(-1, -1, 0, 0, w);
      check("order", w, i);
    end

    set_port(1, 1, 32'h8000_0040, 4'd3);
    do_txn(-1, 0, 1, 8'b1111_1101, w);

    set_port(0, 0, 32'hA000_0000, 4'd3);
    do_txn(1, -1, 0, 0, w);
    set_port(1, 0, 32'hA000_0100, 4'd2);
    do_txn(-1, -1, 0, 0, w);

    // asynchronous reset in the middle of an 8-beat read
    set_port(2, 0, 32'h1FC0_0100, 4'd7);
    @(negedge clk); drive_ports(); #1;
    check("gnt_pre_rst", gnt, 3'b100);
    pend = 0;
    @(negedge clk); req = 0; bus_addr_ok = 1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); bus_idle(); bus_rvalid = 1; bus_rdata = b;
    end
    #1;
    check("rvalid_pre_rst", rvalid, 3'b100);
    #1 rst = 1;
    #1;
    check("rst_mid_out", {gnt, rvalid, rlast, wready, done}, 0);
    check("rst_mid_bus", {bus_req, bus_wvalid, bus_wlast, busy, proto_err}, 0);
    @(negedge clk); bus_idle(); rst = 0; m_starve = 0; m_proto = 0;
    set_port(2, 0, 32'h1FC0_0200, 4'd1);
    do_txn(-1, -1, 0, 0, w);

    win_at = 0;
    for (int a = 1; a <= 10; a++) begin
      pend[1] = 1; p_we[1] = 0; p_len[1] = 0; p_addr[1] = 32'h2000 + a;
      if (win_at == 0) begin pend[2] = 1; p_we[2] = 0; p_len[2] = 0; p_addr[2] = 32'h3000; end
      do_txn(-1, 0, 0, 0, w);
      if (w == 2 && win_at == 0) win_at = a;
      if (a == 10) check("starve_clear", w, 1);
    end
    check("starve_win_at", win_at, STARVE_LIMIT + 1);
    pend = 0;

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) if (!pend[i] && $urandom_range(0, 2) != 0) rand_port(i);
      if (pend == 0) rand_port(2);
      w = model_winner(pend);
      do_txn((!p_we[w] && p_len[w] > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, p_len[w] - 1)) : -1,
             -1, 0, 0, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
